reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised register file: DEPTH words of WIDTH bits, one write port, two registered read ports.
//  Generalises the single-bit enabled flip-flop to a full word-addressed array with byte-lane write strobes.
//  Sits between instruction decode (read addresses) and writeback (write port) in the datapath.
//  Register 0 can be hardwired to zero.
// PARAMETERS
//  WIDTH     32  data width in bits; must be a multiple of 8
//  DEPTH     32  number of registers, 2..256; need not be a power of two
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk       in   1                  single clock; all state updates on posedge clk
//  reset     in   1                  asynchronous, active-low; asserted when 0
//  wr_en     in   1                  write request this cycle
//  wr_addr   in   AW=$clog2(DEPTH)   write register index
//  wr_be     in   WIDTH/8            byte-lane write strobes; bit i covers data[8i+7:8i]
//  wr_data   in   WIDTH              write data
//  rd_en_a   in   1                  port A read request
//  rd_addr_a in   AW                 port A read index
//  rd_data_a out  WIDTH              port A registered read data
//  rd_en_b   in   1                  port B read request
//  rd_addr_b in   AW                 port B read index
//  rd_data_b out  WIDTH              port B registered read data
// BEHAVIOUR
//  - Reset (reset==0, async): all DEPTH registers and rd_data_a/rd_data_b clear to 0 immediately.
//    Reset release is sampled synchronously; first write/read may occur on the first posedge with reset==1.
//  - Write: at posedge, if wr_en && wr_addr<DEPTH && !(ZERO_REG && wr_addr==0), each lane i with wr_be[i]==1
//    takes wr_data lane i; lanes with wr_be[i]==0 hold. wr_en==1 with wr_be==0 changes nothing.
//  - Read: 1-cycle latency. At posedge, if rd_en_x, rd_data_x <= contents of rd_addr_x; if !rd_en_x, rd_data_x holds.
//  - Out-of-range address (>=DEPTH): write ignored; read returns 0.
//  - ZERO_REG==1 and rd_addr_x==0: read returns 0 regardless of write activity.
//  - Both ports may read the same address in the same cycle; both return identical data.
//  - Same-cycle read and write of one address: governed by REG_FILE_BYPASS_EN (below).
//  - Reset asserted mid-operation: any in-flight write is discarded; outputs show 0 while reset==0.
//  - No internal state machine beyond the array and output registers; no stall, no backpressure.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined: read of the address being written in the same cycle returns the merged new word
//    (written lanes from wr_data, unwritten lanes from old contents); zero-register and range rules still apply.
//  REG_FILE_BYPASS_EN undefined: same-cycle read returns the pre-write contents; new value visible on next read.
// STRUCTURE
//  Package reg_file_pkg: default WIDTH/DEPTH constants, function addr_width(depth), byte-merge function
//    merge_be(old, new, be) used by both the write path and the bypass path.
//  Sub-module reg_word: one WIDTH-bit register with per-lane enables and async active-low clear;
//    instantiated DEPTH times via generate (register 0 omitted when ZERO_REG==1).
//  Top level holds write decode, two read muxes and the two output registers.
// TESTING
//  1 reset=0 mid-run after filling regs -> all rd_data 0 at once; after release, reads of reg 5 return 0.
//  2 write reg 3 = 0xDEADBEEF, be=4'hF; next cycle rd_addr_a=3, rd_en_a=1 -> rd_data_a=0xDEADBEEF one clk later.
//  3 reg 3=0xDEADBEEF, write 0x11223344 be=4'b0101 -> reg 3 reads 0xDE22BE44.
//  4 ZERO_REG=1: write reg 0 = 0xFFFFFFFF -> port A and B read 0; DEPTH=20: write addr 25 -> no reg changes, read 25 -> 0.
//  5 rd_en_b=0 while reg under rd_addr_b changes -> rd_data_b holds previous value.
//  6 same-cycle write reg 7=0xA5A5A5A5 and read reg 7 (old 0x0) -> 0xA5A5A5A5 with REG_FILE_BYPASS_EN, 0x0 without.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Holds the default geometry, the address-width helper and the byte-lane
// merge used by both the array write path and the read bypass path.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_MAX_WIDTH = 1024;
  localparam int MERGE_MAX_LANES = MERGE_MAX_WIDTH / 8;

  // Index width for a register file of 'depth' entries (never below 1 bit).
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Byte-lane merge: lanes with be[i]==1 take new_w, the rest keep old_w.
  function automatic logic [MERGE_MAX_WIDTH-1:0] merge_be(
    input logic [MERGE_MAX_WIDTH-1:0] old_w,
    input logic [MERGE_MAX_WIDTH-1:0] new_w,
    input logic [MERGE_MAX_LANES-1:0] be
  );
    logic [MERGE_MAX_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_MAX_LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_param_word.sv
// reg_word: one WIDTH-bit register with per-byte-lane write enables and an
// asynchronous active-low clear. A word is written whenever any lane enable
// is set; unselected lanes keep their old contents.
module reg_word
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int LANES = WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [LANES-1:0] be_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = WIDTH'(merge_be(MERGE_MAX_WIDTH'(q_q), MERGE_MAX_WIDTH'(d_i),
                               MERGE_MAX_LANES'(be_i)));

  // Lane-merged update; clear is asynchronous so outputs drop to 0 at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (|be_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x WIDTH register file, one byte-strobed write port,
// two registered read ports with one cycle of latency.
// Optional macro REG_FILE_BYPASS_EN: a read of the address written in the
// same cycle returns the merged new word instead of the pre-write contents.
// Interface timing: no handshake. wr_en and rd_en_x are single-cycle
// requests accepted unconditionally on the posedge where they are high; there
// is no ready/backpressure, and read data appears one posedge after rd_en_x.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH),
  localparam int LANES   = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic             wr_valid;
  logic [WIDTH-1:0] rd_word_a;
  logic [WIDTH-1:0] rd_word_b;
  logic [WIDTH-1:0] rd_data_a_q;
  logic [WIDTH-1:0] rd_data_b_q;

  // Address lies inside the implemented array (DEPTH need not be 2^AW).
  function automatic logic in_range(input logic [AW-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  // Address maps onto the hardwired zero register.
  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr_valid = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);

`ifdef REG_FILE_BYPASS_EN
  logic [WIDTH-1:0] bypass_word;
  assign bypass_word = WIDTH'(merge_be(MERGE_MAX_WIDTH'(rf_q[wr_addr]),
                                       MERGE_MAX_WIDTH'(wr_data),
                                       MERGE_MAX_LANES'(wr_be)));
`endif

  // Storage array; entry 0 is a constant zero when ZERO_REG is set.
  for (genvar g = 0; g < DEPTH; g++) begin : g_regs
    if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
      assign rf_q[g] = '0;
    end else begin : g_word
      logic [LANES-1:0] lane_we;
      assign lane_we = (wr_valid && (wr_addr == AW'(g))) ? wr_be : '0;
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk_i  (clk),
        .rst_ni (reset),
        .be_i   (lane_we),
        .d_i    (wr_data),
        .q_o    (rf_q[g])
      );
    end
  end

  // Port A read mux: zero for out-of-range or zero register, else array/bypass.
  always_comb begin
    rd_word_a = '0;
    if (in_range(rd_addr_a) && !is_zero_reg(rd_addr_a)) rd_word_a = rf_q[rd_addr_a];
`ifdef REG_FILE_BYPASS_EN
    if (wr_valid && (rd_addr_a == wr_addr)) rd_word_a = bypass_word;
`endif
  end

  // Port B read mux, same rules as port A.
  always_comb begin
    rd_word_b = '0;
    if (in_range(rd_addr_b) && !is_zero_reg(rd_addr_b)) rd_word_b = rf_q[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (wr_valid && (rd_addr_b == wr_addr)) rd_word_b = bypass_word;
`endif
  end

  // Output registers: load on read enable, hold otherwise, clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      if (rd_en_a) rd_data_a_q <= rd_word_a;
      if (rd_en_b) rd_data_b_q <= rd_word_b;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param (WIDTH=32, DEPTH=20, ZERO_REG=1).
// A word-level model of the register file predicts both read ports every
// cycle; directed vectors with literal expectations pin the model.
module tb_reg_file_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 20;
  localparam int AW    = 5;
  localparam int LANES = 4;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [LANES-1:0] wr_be;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_en_b;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;

  int n_vec  = 0;
  int n_miss = 0;
  bit running = 1'b0;

  reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] exp_a;
  logic [WIDTH-1:0] exp_b;

  function automatic bit write_hits();
    return wr_en && (int'(wr_addr) < DEPTH) && (wr_addr != 0);
  endfunction

  function automatic logic [WIDTH-1:0] merged_word();
    logic [WIDTH-1:0] w;
    w = m_mem[int'(wr_addr) % DEPTH];
    for (int l = 0; l < LANES; l++) if (wr_be[l]) w[8*l +: 8] = wr_data[8*l +: 8];
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] addr);
    if (int'(addr) >= DEPTH || addr == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (write_hits() && addr == wr_addr) return merged_word();
`endif
    return m_mem[addr];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      exp_a <= '0;
      exp_b <= '0;
    end else begin
      if (rd_en_a) exp_a <= model_read(rd_addr_a);
      if (rd_en_b) exp_b <= model_read(rd_addr_b);
      if (write_hits()) m_mem[wr_addr] <= merged_word();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (running) begin
      n_vec++;
      if (rd_data_a !== exp_a) begin
        n_miss++;
        $display("FAIL model_a t=%0t actual=%h expected=%h", $time, rd_data_a, exp_a);
      end
      n_vec++;
      if (rd_data_b !== exp_b) begin
        n_miss++;
        $display("FAIL model_b t=%0t actual=%h expected=%h", $time, rd_data_b, exp_b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic ea, input logic [AW-1:0] aa,
                       input logic eb, input logic [AW-1:0] ab);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
    #1 reset = 1'b0;
    #2;
    chk("reset_a", rd_data_a, 32'h0);
    chk("reset_b", rd_data_b, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    running = 1'b1;

    // full-word write then read one cycle later
    drive(1'b1, 5'd3, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("full_write_r3", rd_data_a, 32'hDEADBEEF);

    // byte-lane partial write
    drive(1'b1, 5'd3, 4'b0101, 32'h11223344, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
    chk("lane_write_a", rd_data_a, 32'hDE22BE44);
    chk("lane_write_b", rd_data_b, 32'hDE22BE44);

    // last register, then wr_en with no strobes must not change it
    drive(1'b1, 5'd19, 4'hF, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd19, 4'h0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd19, 1'b0, 5'd0);
    chk("be_zero_r19", rd_data_a, 32'hCAFEF00D);

    // zero register ignores writes, both ports read 0
    drive(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    chk("zero_same_cyc_a", rd_data_a, 32'h0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    chk("zero_reg_a", rd_data_a, 32'h0);
    chk("zero_reg_b", rd_data_b, 32'h0);

    // out-of-range write ignored, out-of-range read returns 0
    drive(1'b1, 5'd25, 4'hF, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd25, 1'b1, 5'd9);
    chk("oob_read_25", rd_data_a, 32'h0);
    chk("oob_alias_r9", rd_data_b, 32'h0);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd20);
    chk("oob_read_31", rd_data_a, 32'h0);
    chk("oob_read_20", rd_data_b, 32'h0);

    // port B holds while disabled even though the register changes
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3);
    chk("hold_load_b", rd_data_b, 32'hDE22BE44);
    drive(1'b1, 5'd3, 4'hF, 32'h00000000, 1'b0, 5'd0, 1'b0, 5'd3);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3);
    chk("hold_b", rd_data_b, 32'hDE22BE44);
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3);
    chk("reload_b", rd_data_b, 32'h0);

    // same-cycle write and read of reg 7
    drive(1'b1, 5'd7, 4'hF, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
`ifdef REG_FILE_BYPASS_EN
    chk("rw_same_a", rd_data_a, 32'hA5A5A5A5);
    chk("rw_same_b", rd_data_b, 32'hA5A5A5A5);
`else
    chk("rw_same_a", rd_data_a, 32'h0);
    chk("rw_same_b", rd_data_b, 32'h0);
`endif
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    chk("rw_next_a", rd_data_a, 32'hA5A5A5A5);
    drive(1'b1, 5'd7, 4'b0011, 32'h00001234, 1'b1, 5'd7, 1'b0, 5'd0);
`ifdef REG_FILE_BYPASS_EN
    chk("rw_lane_a", rd_data_a, 32'hA5A51234);
`else
    chk("rw_lane_a", rd_data_a, 32'hA5A5A5A5);
`endif

    // mixed traffic checked by the model
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
            32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    // fill all registers, then reset mid-run with a write in flight
    for (int r = 1; r < DEPTH; r++) begin
      drive(1'b1, 5'(r), 4'hF, 32'h01010101 * 32'(r), 1'b1, 5'(r - 1), 1'b1, 5'(r));
    end
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd3);
    chk("filled_r5", rd_data_a, 32'h05050505);
    wr_en = 1'b1; wr_addr = 5'd5; wr_be = 4'hF; wr_data = 32'h77777777;
    rd_en_a = 1'b1; rd_addr_a = 5'd5; rd_en_b = 1'b1; rd_addr_b = 5'd3;
    #2 reset = 1'b0;
    #1;
    chk("midrst_a", rd_data_a, 32'h0);
    chk("midrst_b", rd_data_b, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd3);
    chk("post_rst_r5", rd_data_a, 32'h0);
    chk("post_rst_r3", rd_data_b, 32'h0);
    idle();

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
